// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 target bridging READ (0x03) / WRITE (0x02)
// byte streams onto a byte-wide synchronous memory port.
module spi_sram_target #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_ce_n,
  output logic                  spi_miso,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata
);

  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam logic [7:0] LAST_BYTE = 8'(ABYTES - 1);
  localparam logic [7:0] CMD_RD = 8'h03;
  localparam logic [7:0] CMD_WR = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t state;

  logic ce_s1, ce_s2, ce_d;
  logic sck_s1, sck_s2, sck_d;
  logic mosi_s1, mosi_s2;

  logic [1:0] settle;
  logic       armed;

  logic [2:0]            bit_cnt;
  logic [7:0]            abyte;
  logic [7:0]            rx_sr;
  logic [7:0]            tx_sr;
  logic [7:0]            hold;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  is_read;
  logic                  load_pend;
  logic                  re_d;

  logic                  sck_rise;
  logic                  sck_fall;
  logic                  ce_fall;
  logic                  byte_done;
  logic [7:0]            rx_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign sck_rise  = sck_s2 & ~sck_d;
  assign sck_fall  = ~sck_s2 & sck_d;
  assign ce_fall   = ce_d & ~ce_s2;
  assign byte_done = (bit_cnt == 3'd7);
  assign rx_next   = {rx_sr[6:0], mosi_s2};
  assign addr_next = {addr_reg[ADDR_WIDTH-2:0], mosi_s2};

  // Two-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_s1   <= 1'b1;
      ce_s2   <= 1'b1;
      ce_d    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ce_s1   <= spi_ce_n;
      ce_s2   <= ce_s1;
      ce_d    <= ce_s2;
      sck_s1  <= spi_clk;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Arm only once chip enable is seen high from the real pin after reset,
  // so a transaction already in flight at release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && ce_s2) armed <= 1'b1;
    end
  end

  // Protocol FSM, shift registers and registered memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      abyte     <= 8'd0;
      rx_sr     <= 8'd0;
      tx_sr     <= 8'd0;
      hold      <= 8'd0;
      addr_reg  <= '0;
      is_read   <= 1'b0;
      load_pend <= 1'b0;
      re_d      <= 1'b0;
      spi_miso  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d   <= mem_re;
      if (re_d) hold <= mem_rdata;
      if (ce_s2) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        abyte     <= 8'd0;
        spi_miso  <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        if (sck_rise && state != IDLE) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end
        unique case (state)
          IDLE: begin
            spi_miso <= 1'b0;
            if (ce_fall && armed) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              abyte   <= 8'd0;
            end
          end
          CMD: begin
            if (sck_rise && byte_done) begin
              if (rx_next == CMD_RD) begin
                is_read <= 1'b1;
                state   <= ADDR;
              end else if (rx_next == CMD_WR) begin
                is_read <= 1'b0;
                state   <= ADDR;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr_reg <= addr_next;
              if (byte_done) begin
                abyte <= abyte + 8'd1;
                if (abyte == LAST_BYTE) begin
                  if (is_read) begin
                    mem_re    <= 1'b1;
                    mem_addr  <= addr_next;
                    addr_reg  <= addr_next + 1'b1;
                    load_pend <= 1'b1;
                    state     <= READ;
                  end else begin
                    state <= WRITE;
                  end
                end
              end
            end
          end
          READ: begin
            if (sck_rise && byte_done) begin
              mem_re    <= 1'b1;
              mem_addr  <= addr_reg;
              addr_reg  <= addr_reg + 1'b1;
              load_pend <= 1'b1;
            end
            if (sck_fall) begin
              if (load_pend) begin
                tx_sr     <= hold;
                spi_miso  <= hold[7];
                load_pend <= 1'b0;
              end else begin
                tx_sr    <= {tx_sr[6:0], 1'b0};
                spi_miso <= tx_sr[6];
              end
            end
          end
          WRITE: begin
            if (sck_rise && byte_done) begin
              mem_we    <= 1'b1;
              mem_wdata <= rx_next;
              mem_addr  <= addr_reg;
              addr_reg  <= addr_reg + 1'b1;
            end
          end
          IGNORE: begin
            spi_miso <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: random SPI read/write/abort traffic against a
// transaction-level reference of the SRAM target.
module tb_spi_sram_target;

  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_ce_n;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  refmem [0:65535];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  dat_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  spi_sram_target #(.ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_ce_n  (spi_ce_n),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] k,
                                      input logic [15:0] a,
                                      input logic [7:0] d);
    return {6'b0, k, a, d};
  endfunction

  // memory model and strobe monitor, away from the active edge
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
      obs_q.push_back(enc(mem_we ? 2'd1 : 2'd2, mem_addr,
                          mem_we ? mem_wdata : 8'h00));
      if (mem_we) mem[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata = mem[mem_addr];
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (HP) @(negedge clk);
      r[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom);
      repeat (HP) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer(input int part);
    logic [7:0] r;
    rx_q.delete();
    @(negedge clk);
    spi_ce_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (tx_q[i]) begin
      spi_byte(tx_q[i], r);
      rx_q.push_back(r);
    end
    spi_bits(part);
    repeat (HP) @(negedge clk);
    spi_ce_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("miso_idle", 32'(spi_miso), 32'd0);
  endtask

  // reference: one transaction as strobe list and MISO byte list
  task automatic run(input logic [7:0] cmd, input logic [15:0] a,
                     input int n, input int part);
    logic [7:0]  d;
    logic [15:0] p;
    tx_q.delete();
    exp_q.delete();
    exp_rx.delete();
    obs_q.delete();
    tx_q.push_back(cmd);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(a[7:0]);
    repeat (3) exp_rx.push_back(8'h00);
    if (cmd == 8'h03) exp_q.push_back(enc(2'd2, a, 8'h00));
    for (int i = 0; i < n; i++) begin
      d = (dat_q.size() > 0) ? dat_q.pop_front() : 8'($urandom);
      p = a + 16'(i);
      tx_q.push_back(d);
      if (cmd == 8'h02) begin
        exp_q.push_back(enc(2'd1, p, d));
        refmem[p] = d;
        exp_rx.push_back(8'h00);
      end else if (cmd == 8'h03) begin
        exp_rx.push_back(refmem[p]);
        exp_q.push_back(enc(2'd2, p + 16'd1, 8'h00));
      end else begin
        exp_rx.push_back(8'h00);
      end
    end
    xfer(part);
    chk("n_strobes", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("strobe", obs_q[i], exp_q[i]);
    chk("n_rx", 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
      chk("miso_byte", 32'(rx_q[i]), 32'(exp_rx[i]));
  endtask

  initial begin
    logic [7:0]  c;
    logic [7:0]  r;
    logic [15:0] a;
    int          k;
    rst_n     = 1'b0;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_ce_n  = 1'b1;
    mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'($urandom);
      refmem[i] = mem[i];
    end
    mem[16'h1234] = 8'hC3; refmem[16'h1234] = 8'hC3;
    mem[16'h1235] = 8'h5A; refmem[16'h1235] = 8'h5A;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    dat_q = '{8'hAA, 8'h55};
    run(8'h02, 16'h1234, 2, 0);
    chk("w_1234", 32'(mem[16'h1234]), 32'hAA);
    chk("w_1235", 32'(mem[16'h1235]), 32'h55);
    mem[16'h1234] = 8'hC3; refmem[16'h1234] = 8'hC3;
    mem[16'h1235] = 8'h5A; refmem[16'h1235] = 8'h5A;

    run(8'h03, 16'h1234, 2, 0);
    chk("r_byte0", 32'(rx_q[3]), 32'hC3);
    chk("r_byte1", 32'(rx_q[4]), 32'h5A);

    dat_q = '{8'h11, 8'h22};
    run(8'h02, 16'hFFFF, 2, 0);
    chk("wrap_ffff", 32'(mem[16'hFFFF]), 32'h11);
    chk("wrap_0000", 32'(mem[16'h0000]), 32'h22);

    run(8'h9F, 16'h0000, 1, 0);

    run(8'h02, 16'h0010, 0, 5);
    run(8'h03, 16'h0010, 1, 0);

    // reset in the middle of the second read data byte
    @(negedge clk);
    spi_ce_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h03, r);
    spi_byte(8'h12, r);
    spi_byte(8'h34, r);
    spi_byte(8'h00, r);
    spi_bits(4);
    rst_n = 1'b0;
    #1;
    chk("mrst_miso", 32'(spi_miso), 32'd0);
    chk("mrst_we", 32'(mem_we), 32'd0);
    chk("mrst_re", 32'(mem_re), 32'd0);
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    chk("mrst_wdata", 32'(mem_wdata), 32'd0);
    repeat (4) @(negedge clk);
    obs_q.delete();
    rst_n = 1'b1;
    spi_byte(8'h03, r);
    chk("stale_miso0", 32'(r), 32'd0);
    spi_byte(8'h12, r);
    chk("stale_miso1", 32'(r), 32'd0);
    repeat (HP) @(negedge clk);
    spi_ce_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("stale_strobes", 32'(obs_q.size()), 32'd0);
    run(8'h03, 16'h1234, 2, 0);
    chk("post_rst_rd", 32'(rx_q[3]), 32'hC3);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if (k < 4) begin
        c = 8'h02;
      end else if (k < 8) begin
        c = 8'h03;
      end else begin
        do c = 8'($urandom); while (c == 8'h02 || c == 8'h03);
      end
      run(c, a, $urandom_range(0, 4),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_target.md
SPI_SRAM_TARGET -- requirements
Module: spi_sram_target

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, width of the memory address and of the SPI address phase (must be a multiple of 8).
REQ-002 clk  input  1  system clock; all logic in this domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 spi_clk  input  1  SPI serial clock from the initiator, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 spi_mosi  input  1  serial data from the initiator, MSB first.
REQ-006 spi_ce_n  input  1  active-low chip enable from the initiator.
REQ-007 spi_miso  output  1  serial data to the initiator, MSB first.
REQ-008 mem_addr  output  ADDR_WIDTH  backing-memory byte address.
REQ-009 mem_wdata  output  8  backing-memory write data.
REQ-010 mem_we  output  1  one-cycle write strobe.
REQ-011 mem_re  output  1  one-cycle read strobe.
REQ-012 mem_rdata  input  8  read data; valid exactly one clk after mem_re.

Function
REQ-013 spi_clk, spi_mosi and spi_ce_n SHALL each pass through a 2-flop synchronizer; SCK rise/fall events SHALL be detected from the synchronized value.
REQ-014 Supported spi_clk frequency SHALL be at most clk/8; behaviour above this is undefined.
REQ-015 FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
REQ-016 Synchronized spi_ce_n high SHALL force IDLE, clear the bit counter and drive spi_miso 0 on the next clk, from any state.
REQ-017 Synchronized spi_ce_n falling SHALL move IDLE -> CMD with bit counter 0.
REQ-018 Each SCK rise SHALL shift spi_mosi into an 8-bit receive shift register and increment a 3-bit bit counter (wraps 7 -> 0).
REQ-019 CMD: on the 8th rise, byte 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-020 ADDR: ADDR_WIDTH/8 bytes, MSB first, loaded into the address register; after the last address bit go to READ or WRITE per the command.
REQ-021 IGNORE: no memory strobes, spi_miso held 0 until spi_ce_n high.
REQ-022 WRITE: on each 8th rise, assert mem_we for one clk with mem_wdata = received byte, mem_addr = address register; then increment the address.
REQ-023 Read prefetch: on the last address-bit rise, and on each 8th rise in READ, assert mem_re for one clk with mem_addr = address register, then increment the address; the next clk SHALL capture mem_rdata into a hold register.
REQ-024 READ: on the first SCK fall after a prefetch, the transmit shift register SHALL load the hold register and spi_miso SHALL drive its bit 7; each other fall SHALL shift left and drive the next bit.
REQ-025 spi_miso SHALL be 0 in all states except READ.
REQ-026 Address increment SHALL wrap from all-ones to 0 modulo 2^ADDR_WIDTH.
REQ-027 Sequential mode: READ/WRITE continue byte after byte indefinitely until spi_ce_n high.
REQ-028 spi_ce_n high mid-byte SHALL discard the partial byte: no mem_we, no further mem_re.
REQ-029 mem_we and mem_re SHALL never be asserted in the same clk.
REQ-030 mem_addr and mem_wdata SHALL hold their last values when no strobe is asserted.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, spi_miso 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, all shift/hold registers and the bit counter 0, synchronizer flops to ce_n=1, sck=0, mosi=0.
REQ-032 After rst_n deasserts, the block SHALL ignore any transaction whose spi_ce_n falling edge preceded the release.

Verification
REQ-033 Write: ce_n low, send 02 12 34 AA 55, ce_n high -> mem_we pulses at 0x1234 data 0xAA, then 0x1235 data 0x55; exactly two mem_we.
REQ-034 Read: memory model 0x1234=0xC3, 0x1235=0x5A; send 03 12 34 + 16 dummy clocks -> MISO bytes 0xC3, 0x5A; mem_re at 0x1234, 0x1235, 0x1236.
REQ-035 Wrap: write 02 FF FF 11 22 -> mem_we at 0xFFFF data 0x11, then 0x0000 data 0x22.
REQ-036 Unknown command 0x9F followed by 24 clocks -> no mem_we/mem_re, spi_miso constant 0.
REQ-037 Abort: send 02 00 10 + 5 bits, ce_n high -> no mem_we; next transaction 03 00 10 behaves normally.
REQ-038 Reset mid-READ: assert rst_n low during the 2nd data byte -> all outputs 0 immediately; after release and a fresh ce_n cycle, a read returns correct data.
